// File: rtl/nios_dut_pio_out.sv
// Avalon-MM output PIO: a data register with set/clear aliases plus a timed
// pulse mask that XORs onto the pins for PULSE_LEN cycles.
`timescale 1ns/1ps
module nios_dut_pio_out #(
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PULSE_LEN   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_port
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [2:0]  A_DATA  = 3'd0;
  localparam logic [2:0]  A_PULSE = 3'd2;
  localparam logic [2:0]  A_SET   = 3'd4;
  localparam logic [2:0]  A_CLR   = 3'd5;
  localparam logic [15:0] PLEN    = 16'(PULSE_LEN);

  state_t      state, state_nxt;
  logic [31:0] data_reg, data_nxt;
  logic [31:0] mask_reg, mask_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        busy, busy_nxt;
  logic        overrun, overrun_nxt;
  logic        wr, rd;

  assign wr = chipselect & write;
  assign rd = chipselect & read & ~write;

  always_comb begin
    data_nxt    = data_reg;
    state_nxt   = state;
    mask_nxt    = mask_reg;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    overrun_nxt = overrun;

    if (wr) begin
      case (address)
        A_DATA:  data_nxt = writedata;
        A_SET:   data_nxt = data_reg | writedata;
        A_CLR:   data_nxt = data_reg & ~writedata;
        default: ;
      endcase
    end

    // Read-clear is applied first so an overrun set on the same edge wins.
    if (rd && address == A_PULSE) overrun_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (wr && address == A_PULSE && writedata != 32'h0) begin
          mask_nxt  = writedata;
          cnt_nxt   = PLEN;
          busy_nxt  = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        cnt_nxt = cnt - 16'd1;
        if (cnt == 16'd1) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        if (wr && address == A_PULSE) overrun_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      data_reg <= RESET_VALUE;
      mask_reg <= 32'h0;
      cnt      <= 16'h0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      readdata <= 32'h0;
      out_port <= RESET_VALUE;
    end else begin
      state    <= state_nxt;
      data_reg <= data_nxt;
      mask_reg <= mask_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      overrun  <= overrun_nxt;
      // Pins come from next-state values so they update one cycle after a write.
      out_port <= data_nxt ^ (busy_nxt ? mask_nxt : 32'h0);
      if (rd) begin
        case (address)
          A_DATA:  readdata <= data_reg;
          A_PULSE: readdata <= {30'b0, overrun, busy};
          default: readdata <= 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_dut_pio_out.sv
// Directed bench for nios_dut_pio_out: register map, set/clear, pulse timing,
// overrun behaviour and reset abort.
`timescale 1ns/1ps
module tb_nios_dut_pio_out;

  localparam logic [31:0] RV = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, write, read;
  logic [31:0] writedata, readdata, out_port;
  logic [31:0] rv;
  int          tests = 0;
  int          fails = 0;

  nios_dut_pio_out #(.RESET_VALUE(RV), .PULSE_LEN(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .read(read), .writedata(writedata),
    .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  // Returns #1 after the accepting edge.
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    idle_bus();
    d = readdata;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    idle_bus();
    address = 3'd0; writedata = 32'h0;
    reset = 1'b1;
    #12;
    chk("reset_out", out_port, RV);
    chk("reset_rd", readdata, 32'h0);
    @(negedge clk); reset = 1'b0;

    // First access right after reset release
    bus_rd(3'd0, rv);   chk("rd_data_rv", rv, RV);

    bus_wr(3'd0, 32'hA5A5_A5A5); chk("wr_data_out", out_port, 32'hA5A5_A5A5);
    bus_rd(3'd0, rv);   chk("rd_data_a5", rv, 32'hA5A5_A5A5);
    cyc(); cyc();
    chk("rd_hold", readdata, 32'hA5A5_A5A5);

    // Set / clear aliases and reserved addresses
    bus_wr(3'd0, 32'h0000_FF00);
    bus_wr(3'd4, 32'h0000_000F); chk("outset", out_port, 32'h0000_FF0F);
    bus_wr(3'd5, 32'h0000_0F00); chk("outclr", out_port, 32'h0000_F00F);
    bus_rd(3'd4, rv);   chk("rd_addr4", rv, 32'h0);
    bus_rd(3'd5, rv);   chk("rd_addr5", rv, 32'h0);
    bus_wr(3'd1, 32'hFFFF_FFFF); chk("wr_rsvd1", out_port, 32'h0000_F00F);
    bus_wr(3'd7, 32'hFFFF_FFFF); chk("wr_rsvd7", out_port, 32'h0000_F00F);
    bus_rd(3'd0, rv);   chk("rd_data_f00f", rv, 32'h0000_F00F);
    bus_rd(3'd1, rv);   chk("rd_addr1", rv, 32'h0);

    // Basic pulse: mask 3 visible for exactly 8 cycles
    bus_wr(3'd0, 32'h0);
    bus_wr(3'd2, 32'h3); chk("pulse_start", out_port, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin address = 3'd2; chipselect = 1'b1; read = 1'b1; end
      @(posedge clk); #1;
      idle_bus();
      chk($sformatf("pulse_c%0d", i), out_port, (i < 8) ? 32'h3 : 32'h0);
      if (i == 1) chk("pulse_stat_busy", readdata, 32'h1);
    end
    bus_rd(3'd2, rv);   chk("pulse_stat_done", rv, 32'h0);

    // Overrun write mid-pulse plus a DATA write under the pulse
    bus_wr(3'd2, 32'h1); chk("pulse2_start", out_port, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) begin address = 3'd2; writedata = 32'hF0;  chipselect = 1'b1; write = 1'b1; end
      if (i == 3) begin address = 3'd0; writedata = 32'h100; chipselect = 1'b1; write = 1'b1; end
      @(posedge clk); #1;
      idle_bus();
      chk($sformatf("ovr_c%0d", i), out_port,
          (i < 8) ? (((i >= 3) ? 32'h100 : 32'h0) ^ 32'h1) : 32'h100);
    end
    bus_rd(3'd2, rv);   chk("ovr_stat", rv, 32'h2);
    bus_rd(3'd2, rv);   chk("ovr_cleared", rv, 32'h0);

    // PULSE write on the final active edge counts as an overrun
    bus_wr(3'd2, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) begin address = 3'd2; writedata = 32'h4; chipselect = 1'b1; write = 1'b1; end
      @(posedge clk); #1;
      idle_bus();
    end
    chk("end_edge_out", out_port, 32'h100);
    cyc(); cyc();
    chk("end_edge_nopulse", out_port, 32'h100);
    bus_rd(3'd2, rv);   chk("end_edge_stat", rv, 32'h2);
    bus_rd(3'd2, rv);   chk("end_edge_clr", rv, 32'h0);

    // Reset aborts an active pulse
    bus_wr(3'd0, 32'h12);
    bus_wr(3'd2, 32'hFF); chk("rst_pulse_on", out_port, 32'hED);
    bus_rd(3'd0, rv);   chk("rst_pre_rd", rv, 32'h12);
    cyc();
    reset = 1'b1; #1;
    chk("rst_async_out", out_port, RV);
    chk("rst_async_rd", readdata, 32'h0);
    @(negedge clk); reset = 1'b0;
    bus_rd(3'd2, rv);   chk("rst_stat", rv, 32'h0);
    bus_wr(3'd2, 32'h0); chk("zero_pulse_out", out_port, RV);
    for (int i = 0; i < 10; i++) cyc();
    chk("no_residual", out_port, RV);
    bus_rd(3'd2, rv);   chk("zero_pulse_stat", rv, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios_dut_pio_out.md
NIOS_DUT_PIO_OUT -- requirements
Module: nios_dut_pio_out

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset; polarity and synchronicity are fixed.
REQ-002 Parameter RESET_VALUE, default 32'h0: value of the data register after reset.
REQ-003 Parameter PULSE_LEN, default 8: pulse duration in clk cycles; legal range 1..65535.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 address  in  3  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select; all accesses qualified by it.
REQ-008 write  in  1  write strobe; an access is a write when chipselect=1 and write=1.
REQ-009 read  in  1  read strobe; an access is a read when chipselect=1, read=1 and write=0.
REQ-010 writedata  in  32  write data.
REQ-011 readdata  out  32  registered read data.
REQ-012 out_port  out  32  output pins.

Function
REQ-013 Register map: 0 DATA (R/W); 2 PULSE (W: mask, R: status); 4 OUTSET (W only); 5 OUTCLEAR (W only); 1, 3, 6 and 7 are reserved, read 0, and ignore writes.
REQ-014 A write to DATA SHALL load data_reg with writedata.
REQ-015 A write to OUTSET SHALL perform data_reg <= data_reg | writedata.
REQ-016 A write to OUTCLEAR SHALL perform data_reg <= data_reg & ~writedata.
REQ-017 out_port SHALL equal data_reg XOR (busy ? mask_reg : 0), driven only from flops with no combinational path from bus inputs, so a write becomes visible on out_port in the cycle after its accepting edge.
REQ-018 Pulse FSM states: IDLE, ACTIVE.
REQ-019 In IDLE, a PULSE write with nonzero writedata SHALL load mask_reg <= writedata and cnt <= PULSE_LEN (16-bit), set busy, and enter ACTIVE.
REQ-020 In IDLE, a PULSE write of zero SHALL be ignored: state, mask_reg and flags unchanged.
REQ-021 In ACTIVE, cnt SHALL decrement by 1 each cycle; on the edge where cnt=1 it SHALL clear busy and return to IDLE, so the inverted bits are visible for exactly PULSE_LEN cycles.
REQ-022 In ACTIVE, a PULSE write SHALL be ignored (mask_reg and cnt unchanged) and SHALL set the sticky overrun flag.
REQ-023 A PULSE write accepted on the same edge that ACTIVE ends SHALL be treated as an ACTIVE write (ignored, overrun set).
REQ-024 DATA, OUTSET and OUTCLEAR writes during ACTIVE SHALL update data_reg normally; the pulse continues to XOR onto the new value.
REQ-025 A read SHALL register readdata on the next edge (1-cycle latency).
REQ-026 Read values: DATA returns data_reg (not out_port); PULSE returns {30'b0, overrun, busy}; all other addresses return 0.
REQ-027 readdata SHALL hold its value when no read access is in progress.
REQ-028 A read of PULSE SHALL clear overrun after its value is captured.
REQ-029 If the overrun set (REQ-022) and the read-clear (REQ-028) occur on the same edge, set SHALL win.

Reset
REQ-030 While reset=1, asynchronously: data_reg=RESET_VALUE, mask_reg=0, cnt=0, busy=0, overrun=0, state=IDLE, readdata=0, out_port=RESET_VALUE.
REQ-031 Reset asserted during ACTIVE SHALL abort the pulse immediately, with no residual XOR after reset deassertion.
REQ-032 The first access SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-033 Write DATA=0xA5A5A5A5, then read address 0 -> out_port=0xA5A5A5A5 one cycle after the write; readdata=0xA5A5A5A5 one cycle after the read.
REQ-034 From DATA=0x0000FF00: OUTSET 0x0000000F, then OUTCLEAR 0x00000F00 -> out_port=0x0000F00F; reads of address 4 and 5 return 0.
REQ-035 With PULSE_LEN=8 and DATA=0: write PULSE=0x00000003 -> out_port=0x3 for exactly 8 cycles, then 0; PULSE status reads 0x1 while active and 0x0 after.
REQ-036 During an active pulse, write PULSE=0xF0 -> ignored, out_port unchanged, pulse ends on schedule; read PULSE returns 0x2 (or 0x3 if still busy); the next read returns overrun=0.
REQ-037 Assert reset mid-pulse with DATA=0x12 -> out_port=RESET_VALUE immediately, status 0; write PULSE=0 afterwards -> no pulse, busy stays 0.
